// File: rtl/spi_mem_pkg.sv
// Shared constants and FSM state type for the SPI memory responder.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Bit boundaries within a frame: command byte, command+address, full frame.
  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned HDR_BITS   = 32;
  localparam int unsigned FRAME_BITS = 64;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRxData,
    StTxData,
    StIgnore,
    StEnd
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes the SPI pins into the system clock domain and detects
// spi_clk rising/falling edges and the chip-select falling edge.
module spi_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic spi_clk_i,
  input  logic spi_mosi_i,
  input  logic spi_cs_n_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic mosi_o,
  output logic cs_n_o,
  output logic cs_fall_o
);

  logic [SyncStages-1:0] sclk_sync_q;
  logic [SyncStages-1:0] mosi_sync_q;
  logic [SyncStages-1:0] cs_sync_q;
  logic                  sclk_prev_q;
  logic                  cs_prev_q;

  // Synchronizer chains plus one history flop each for edge detection.
  // The cs_n chain resets to "selected" so a frame already in progress when
  // reset releases never produces a falling edge and is not picked up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], spi_cs_n_i};
      sclk_prev_q <= sclk_sync_q[SyncStages-1];
      cs_prev_q   <= cs_sync_q[SyncStages-1];
    end
  end

  assign sclk_rise_o = sclk_sync_q[SyncStages-1] & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_sync_q[SyncStages-1] & sclk_prev_q;
  assign mosi_o      = mosi_sync_q[SyncStages-1];
  assign cs_n_o      = cs_sync_q[SyncStages-1];
  assign cs_fall_o   = ~cs_sync_q[SyncStages-1] & cs_prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target backing READ (0x03) / WRITE (0x02) frames with a local
// word-addressed register array. All logic runs on CLK; SPI pins are oversampled.
// Define SPI_RESP_BURST_EN to let frames continue past 64 bits as a burst over
// consecutive word indices (wrapping modulo DEPTH).
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_mosi,
  input  logic spi_cs_n,
  output logic spi_miso,
  output logic frame_done,
  output logic frame_abort,
  output logic cmd_err
);

`ifdef SPI_RESP_BURST_EN
  localparam bit BurstEn = 1'b1;
`else
  localparam bit BurstEn = 1'b0;
`endif

  localparam logic [5:0] CmdLast   = 6'(CMD_BITS - 1);
  localparam logic [5:0] HdrLast   = 6'(HDR_BITS - 1);
  localparam logic [5:0] FrameLast = 6'(FRAME_BITS - 1);
  localparam logic [4:0] WordLast  = 5'(HDR_BITS - 1);

  logic sclk_rise, sclk_fall, mosi_s, cs_n_s, cs_fall;

  spi_sync_edge #(
    .SyncStages (SYNC_STAGES)
  ) u_sync (
    .clk_i       (CLK),
    .rst_ni      (reset_n),
    .spi_clk_i   (spi_clk),
    .spi_mosi_i  (spi_mosi),
    .spi_cs_n_i  (spi_cs_n),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .mosi_o      (mosi_s),
    .cs_n_o      (cs_n_s),
    .cs_fall_o   (cs_fall)
  );

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic            full_q;      // 64 bits seen in this frame
  logic            is_read_q;
  logic [31:0]     shift_q;
  logic [31:0]     tx_q;
  logic [AW-1:0]   idx_q;
  logic            miso_q, done_q, abort_q, err_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_idx_q;
  logic [31:0]     wr_data_q;
  logic [31:0]     mem_q [DEPTH];

  logic [31:0]     shift_nxt;
  logic [AW-1:0]   addr_idx;
  logic [AW-1:0]   idx_inc;

  // shift_nxt holds {cmd, addr[23:0]} on the 32nd rise, so its low bits are the address.
  assign shift_nxt = {shift_q[30:0], mosi_s};
  assign addr_idx  = shift_nxt[AW+1:2];
  assign idx_inc   = idx_q + AW'(1);

  // Frame FSM: CS-high takes priority over any SCLK edge seen in the same cycle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      is_read_q <= 1'b0;
      shift_q   <= '0;
      tx_q      <= '0;
      idx_q     <= '0;
      miso_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= 1'b0;
      if (cs_n_s) begin
        if (state_q != StIdle && state_q != StIgnore) begin
          done_q  <= full_q;
          abort_q <= ~full_q;
        end
        state_q <= StIdle;
        cnt_q   <= '0;
        full_q  <= 1'b0;
        miso_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q <= StCmd;
              cnt_q   <= '0;
            end
          end
          StCmd: begin
            if (sclk_rise) begin
              shift_q <= shift_nxt;
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == CmdLast) begin
                if (shift_nxt[7:0] == CMD_READ || shift_nxt[7:0] == CMD_WRITE) begin
                  is_read_q <= (shift_nxt[7:0] == CMD_READ);
                  state_q   <= StAddr;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= StIgnore;
                end
              end
            end
          end
          StAddr: begin
            if (sclk_rise) begin
              shift_q <= shift_nxt;
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == HdrLast) begin
                idx_q <= addr_idx;
                if (is_read_q) begin
                  tx_q    <= mem_q[addr_idx];
                  state_q <= StTxData;
                end else begin
                  state_q <= StRxData;
                end
              end
            end
          end
          StRxData: begin
            if (sclk_rise) begin
              shift_q <= shift_nxt;
              cnt_q   <= cnt_q + 6'd1;
              if (cnt_q == FrameLast) full_q <= 1'b1;
              // Commit only whole words; a partial word never reaches memory.
              if (cnt_q[4:0] == WordLast) begin
                wr_en_q   <= 1'b1;
                wr_idx_q  <= idx_q;
                wr_data_q <= shift_nxt;
                idx_q     <= idx_inc;
                if (!BurstEn) state_q <= StEnd;
              end
            end
          end
          StTxData: begin
            if (sclk_fall) begin
              miso_q <= tx_q[31];
              tx_q   <= {tx_q[30:0], 1'b0};
            end
            if (sclk_rise) begin
              cnt_q <= cnt_q + 6'd1;
              if (cnt_q == FrameLast) full_q <= 1'b1;
              if (cnt_q[4:0] == WordLast) begin
                idx_q <= idx_inc;
                tx_q  <= mem_q[idx_inc];
                if (!BurstEn) state_q <= StEnd;
              end
            end
          end
          StIgnore, StEnd: begin
            if (sclk_fall) miso_q <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Storage array; writes land one CLK after the last data bit is sampled.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_q) begin
      mem_q[wr_idx_q] <= wr_data_q;
    end
  end

  assign spi_miso    = miso_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: table of SPI frames with expected
// miso data and status-pulse counts, plus reset-mid-frame and burst sequences.
module tb_spi_mem_responder;

  localparam int Half = 8;  // SCLK half-period in CLK cycles

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_miso, frame_done, frame_abort, cmd_err;

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int err_cnt = 0;
  logic rst_miso = 1'b1;

  spi_mem_responder #(
    .DEPTH       (16),
    .AW          (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .cmd_err     (cmd_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
    if (cmd_err)     err_cnt++;
  end

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] data;
    int          nbits;
    logic [31:0] exp_rd;
    int          exp_done;
    int          exp_abort;
    int          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame MSB-first from tx[127]; miso is captured at each rise.
  // rst_at >= 0 pulses reset_n right after that rise.
  task automatic spi_xfer(input logic [127:0] tx, input int nbits, input int rst_at,
                          output logic [127:0] rx, output int nd, output int na,
                          output int ne);
    int d0, a0, e0;
    d0 = done_cnt;
    a0 = abort_cnt;
    e0 = err_cnt;
    rx = '0;
    spi_cs_n = 1'b0;
    repeat (Half) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[127-i];
      repeat (Half) @(negedge CLK);
      spi_clk = 1'b1;
      rx[127-i] = spi_miso;
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        rst_miso = spi_miso;
        repeat (3) @(negedge CLK);
        reset_n = 1'b1;
      end
      repeat (Half) @(negedge CLK);
      spi_clk = 1'b0;
    end
    repeat (Half) @(negedge CLK);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (2 * Half) @(negedge CLK);
    nd = done_cnt - d0;
    na = abort_cnt - a0;
    ne = err_cnt - e0;
  endtask

  task automatic read_word(input string name, input logic [23:0] addr, input logic [31:0] exp);
    logic [127:0] rx;
    int nd, na, ne;
    spi_xfer({8'h03, addr, 96'h0}, 64, -1, rx, nd, na, ne);
    check({name, "_data"}, rx, {32'h0, exp, 64'h0});
    check({name, "_done"}, 128'(nd), 128'd1);
  endtask

  initial begin
    logic [127:0] rx, exp_rx;
    int nd, na, ne;

    vecs[0] = '{"wr10",    8'h02, 24'h000010, 32'hDEADBEEF, 64, 32'h0,        1, 0, 0};
    vecs[1] = '{"rd10",    8'h03, 24'h000010, 32'h0,        64, 32'hDEADBEEF, 1, 0, 0};
    vecs[2] = '{"bad9f",   8'h9F, 24'h000000, 32'h0,        64, 32'h0,        0, 0, 1};
    vecs[3] = '{"rd10b",   8'h03, 24'h000010, 32'h0,        64, 32'hDEADBEEF, 1, 0, 0};
    vecs[4] = '{"rd04",    8'h03, 24'h000004, 32'h0,        64, 32'h0,        1, 0, 0};
    vecs[5] = '{"wr04_48", 8'h02, 24'h000004, 32'h12345678, 48, 32'h0,        0, 1, 0};
    vecs[6] = '{"rd04b",   8'h03, 24'h000004, 32'h0,        64, 32'h0,        1, 0, 0};
    vecs[7] = '{"wr40",    8'h02, 24'h000040, 32'hA5A5A5A5, 64, 32'h0,        1, 0, 0};
    vecs[8] = '{"rd00",    8'h03, 24'h000000, 32'h0,        64, 32'hA5A5A5A5, 1, 0, 0};
    vecs[9] = '{"rd40",    8'h03, 24'h000040, 32'h0,        64, 32'hA5A5A5A5, 1, 0, 0};

    // Reset state
    repeat (4) @(negedge CLK);
    check("rst_miso",  128'(spi_miso),    128'd0);
    check("rst_done",  128'(frame_done),  128'd0);
    check("rst_abort", 128'(frame_abort), 128'd0);
    check("rst_err",   128'(cmd_err),     128'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge CLK);

    for (int v = 0; v < 10; v++) begin
      spi_xfer({vecs[v].cmd, vecs[v].addr, vecs[v].data, 64'h0}, vecs[v].nbits, -1,
               rx, nd, na, ne);
      exp_rx = (vecs[v].cmd == 8'h03) ? {32'h0, vecs[v].exp_rd, 64'h0} : 128'h0;
      check({vecs[v].name, "_miso"},  rx,          exp_rx);
      check({vecs[v].name, "_done"},  128'(nd),    128'(vecs[v].exp_done));
      check({vecs[v].name, "_abort"}, 128'(na),    128'(vecs[v].exp_abort));
      check({vecs[v].name, "_err"},   128'(ne),    128'(vecs[v].exp_err));
    end

    // Reset asserted after the 41st rise of a READ of 0xDEADBEEF
    spi_xfer({8'h03, 24'h000010, 96'h0}, 64, 40, rx, nd, na, ne);
    check("rstmid_bit_before", 128'(rx[87]), 128'd1);
    check("rstmid_miso_now",   128'(rst_miso), 128'd0);
    check("rstmid_tail",       128'(rx[86:64]), 128'd0);
    check("rstmid_done",       128'(nd), 128'd0);
    check("rstmid_abort",      128'(na), 128'd0);
    read_word("rstmid_rd10", 24'h000010, 32'h0);
    read_word("rstmid_rd00", 24'h000000, 32'h0);

    // Fresh frames after reset, then a 96-bit write/read across the top index
    spi_xfer({8'h02, 24'h000008, 32'hCAFEF00D, 64'h0}, 64, -1, rx, nd, na, ne);
    check("post_wr08_done", 128'(nd), 128'd1);
    read_word("post_rd08", 24'h000008, 32'hCAFEF00D);

    spi_xfer({8'h02, 24'h00003C, 32'h11111111, 32'h22222222, 32'h0}, 96, -1, rx, nd, na, ne);
    check("wr3c96_done",  128'(nd), 128'd1);
    check("wr3c96_abort", 128'(na), 128'd0);
    spi_xfer({8'h03, 24'h00003C, 96'h0}, 96, -1, rx, nd, na, ne);
`ifdef SPI_RESP_BURST_EN
    check("rd3c96_miso", rx, {32'h0, 32'h11111111, 32'h22222222, 32'h0});
    check("rd3c96_done", 128'(nd), 128'd1);
    read_word("wrap_rd00", 24'h000000, 32'h22222222);
`else
    check("rd3c96_miso", rx, {32'h0, 32'h11111111, 64'h0});
    check("rd3c96_done", 128'(nd), 128'd1);
    read_word("nowrap_rd00", 24'h000000, 32'h0);
`endif
    read_word("rd3c", 24'h00003C, 32'h11111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
